// File: rtl/param_controller_fsm_if.sv
// ---------------------------------------------------------------------------
// param_controller_fsm_if
// Instruction-fetch bus between the controller and instruction memory / IR.
//
// Parameter:
//   OPCODE_W - width of the IR opcode field
//
// Signals:
//   MemReq  - controller requests an instruction fetch
//   MemAck  - memory has data for the current fetch
//   LoadIR  - controller loads the instruction register
//   Opcode  - opcode field of the IR, valid the cycle after LoadIR
//
// Modports:
//   master - controller side (drives MemReq/LoadIR, samples MemAck/Opcode)
//   slave  - memory / IR side
// ---------------------------------------------------------------------------
interface param_controller_fsm_if #(
   parameter int OPCODE_W = 4
);
   logic                MemReq;
   logic                MemAck;
   logic                LoadIR;
   logic [OPCODE_W-1:0] Opcode;

   modport master (
      output MemReq,
      output LoadIR,
      input  MemAck,
      input  Opcode
   );

   modport slave (
      input  MemReq,
      input  LoadIR,
      output MemAck,
      output Opcode
   );
endinterface

// File: rtl/param_controller_fsm.sv
// ---------------------------------------------------------------------------
// param_controller_fsm
// Multi-cycle datapath controller: FETCH (with memory request/acknowledge),
// DECODE, EXEC, plus HALT and FAULT states. Decodes a latched opcode into the
// PC / accumulator / register / ALU strobes.
//
// Parameters:
//   OPCODE_W      - opcode width (>= 4); bits above [3:0] must be zero
//   ALU_SEL_W     - SelALU width (>= 4); opcode[3:0] is zero-extended
//   FETCH_TIMEOUT - max FETCH cycles without MemAck before FAULT, 0 = off
//
// Ports:
//   Clk, CLB            - clock (rising edge), synchronous active-low reset
//   fetchBus (master)   - MemReq/LoadIR out, MemAck/Opcode in
//   Z, C                - accumulator-zero and carry flags (jumps only)
//   Resume              - leave HALT or FAULT
//   IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU - datapath strobes
//   Halted, Fault       - state is HALT / FAULT
//   IllegalOp           - sticky illegal-opcode flag, cleared by reset only
//
// Optional feature (macro CTRL_PERF_CNT_EN):
//   RetiredCnt - EXEC cycles, wrapping 16-bit counter
//   StallCnt   - FETCH cycles without MemAck, saturating 16-bit counter
// ---------------------------------------------------------------------------
module param_controller_fsm #(
   parameter int OPCODE_W      = 4,
   parameter int ALU_SEL_W     = 4,
   parameter int FETCH_TIMEOUT = 15
) (
   input  logic                 Clk,
   input  logic                 CLB,
   param_controller_fsm_if.master fetchBus,
   input  logic                 Z,
   input  logic                 C,
   input  logic                 Resume,
   output logic                 IncPC,
   output logic                 SelPC,
   output logic                 LoadPC,
   output logic                 LoadReg,
   output logic                 LoadAcc,
   output logic [1:0]           SelAcc,
   output logic [ALU_SEL_W-1:0] SelALU,
   output logic                 Halted,
   output logic                 Fault,
   output logic                 IllegalOp
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [15:0]          RetiredCnt,
   output logic [15:0]          StallCnt
`endif
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StHalt,
      StFault
   } state_t;

   // The counter only ever needs to hold values up to FETCH_TIMEOUT.
   localparam int CNT_W = (FETCH_TIMEOUT > 0) ? $clog2(FETCH_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      (FETCH_TIMEOUT > 0) ? CNT_W'(FETCH_TIMEOUT - 1) : '0;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic             illegal_q, illegal_d;
   logic             opLegal;

   // Legal opcodes have nothing above bit 3 and are not the unused 1001 slot.
   assign opLegal = ((fetchBus.Opcode >> 4) == '0) &&
                    (fetchBus.Opcode[3:0] != 4'b1001);

   // State, timeout counter, latched opcode and sticky flag all reset together.
   always_ff @(posedge Clk) begin
      if (!CLB) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         op_q      <= 4'b0000;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state and output decode. The counter is zero outside FETCH, so
   // both a MemAck and a Resume out of FAULT start the next fetch from zero.
   // A MemAck on the limit cycle takes the DECODE branch before the timeout
   // is considered.
   always_comb begin
      state_d         = state_q;
      cnt_d           = '0;
      op_d            = op_q;
      illegal_d       = illegal_q;
      fetchBus.MemReq = 1'b0;
      fetchBus.LoadIR = 1'b0;
      IncPC           = 1'b0;
      SelPC           = 1'b0;
      LoadPC          = 1'b0;
      LoadReg         = 1'b0;
      LoadAcc         = 1'b0;
      SelAcc          = 2'b00;
      SelALU          = '0;
      Halted          = 1'b0;
      Fault           = 1'b0;

      case (state_q)
         StIdle: begin
            state_d = StFetch;
         end
         StFetch: begin
            fetchBus.MemReq = 1'b1;
            if (fetchBus.MemAck) begin
               fetchBus.LoadIR = 1'b1;
               IncPC           = 1'b1;
               state_d         = StDecode;
            end else if (FETCH_TIMEOUT != 0) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = StFault;
               end
            end
         end
         StDecode: begin
            op_d    = opLegal ? fetchBus.Opcode[3:0] : 4'b0000;
            state_d = StExec;
            if (!opLegal) begin
               illegal_d = 1'b1;
            end
         end
         StExec: begin
            state_d = StFetch;
            case (op_q)
               4'b0001, 4'b0010, 4'b0011, 4'b1011, 4'b1100: begin
                  SelALU  = ALU_SEL_W'(op_q);
                  LoadAcc = 1'b1;
               end
               4'b0100: begin
                  SelAcc  = 2'b01;
                  LoadAcc = 1'b1;
               end
               4'b0101: LoadReg = 1'b1;
               4'b1101: begin
                  SelAcc  = 2'b10;
                  LoadAcc = 1'b1;
               end
               4'b0110: LoadPC = Z;
               4'b0111: begin
                  LoadPC = Z;
                  SelPC  = 1'b1;
               end
               4'b1000: LoadPC = C;
               4'b1010: begin
                  LoadPC = C;
                  SelPC  = 1'b1;
               end
               4'b1111: state_d = StHalt;
               default: ;
            endcase
         end
         StHalt: begin
            Halted = 1'b1;
            if (Resume) begin
               state_d = StFetch;
            end
         end
         StFault: begin
            Fault = 1'b1;
            if (Resume) begin
               state_d = StFetch;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign IllegalOp = illegal_q;

`ifdef CTRL_PERF_CNT_EN
   logic [15:0] retired_q, retired_d;
   logic [15:0] stall_q, stall_d;

   // Retired count wraps; stall count sticks at all-ones so it never lies low.
   always_comb begin
      retired_d = retired_q;
      stall_d   = stall_q;
      if (state_q == StExec) begin
         retired_d = retired_q + 16'd1;
      end
      if ((state_q == StFetch) && !fetchBus.MemAck && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   // Performance counters clear with the rest of the controller.
   always_ff @(posedge Clk) begin
      if (!CLB) begin
         retired_q <= 16'd0;
         stall_q   <= 16'd0;
      end else begin
         retired_q <= retired_d;
         stall_q   <= stall_d;
      end
   end

   assign RetiredCnt = retired_q;
   assign StallCnt   = stall_q;
`endif

endmodule

// File: tb/tb_param_controller_fsm.sv
// ---------------------------------------------------------------------------
// tb_param_controller_fsm
// Self-checking bench for param_controller_fsm, built with OPCODE_W = 8 and
// ALU_SEL_W = 6 so upper opcode bits and SelALU zero-extension are exercised.
// Expected strobes come from an instruction-level table of the controller's
// behaviour; random MemAck delays, flags and don't-care inputs are applied.
// With CTRL_PERF_CNT_EN defined the performance counters are checked too.
// ---------------------------------------------------------------------------
module tb_param_controller_fsm;

   localparam int OPCODE_W      = 8;
   localparam int ALU_SEL_W     = 6;
   localparam int FETCH_TIMEOUT = 15;

   typedef struct packed {
      logic       memReq;
      logic       loadIR;
      logic       incPC;
      logic       selPC;
      logic       loadPC;
      logic       loadReg;
      logic       loadAcc;
      logic [1:0] selAcc;
      logic [5:0] selALU;
      logic       halted;
      logic       fault;
   } outVec_t;

   logic                 Clk = 1'b0;
   logic                 CLB;
   logic                 Z;
   logic                 C;
   logic                 Resume;
   logic                 IncPC;
   logic                 SelPC;
   logic                 LoadPC;
   logic                 LoadReg;
   logic                 LoadAcc;
   logic [1:0]           SelAcc;
   logic [ALU_SEL_W-1:0] SelALU;
   logic                 Halted;
   logic                 Fault;
   logic                 IllegalOp;
`ifdef CTRL_PERF_CNT_EN
   logic [15:0]          RetiredCnt;
   logic [15:0]          StallCnt;
`endif

   int compared   = 0;
   int mismatched = 0;

   // Instruction-level model state.
   logic modelIllegal = 1'b0;
   int   modelRetired = 0;
   int   modelStall   = 0;

   param_controller_fsm_if #(.OPCODE_W(OPCODE_W)) busIf ();

   param_controller_fsm #(
      .OPCODE_W      (OPCODE_W),
      .ALU_SEL_W     (ALU_SEL_W),
      .FETCH_TIMEOUT (FETCH_TIMEOUT)
   ) dut (
      .Clk       (Clk),
      .CLB       (CLB),
      .fetchBus  (busIf),
      .Z         (Z),
      .C         (C),
      .Resume    (Resume),
      .IncPC     (IncPC),
      .SelPC     (SelPC),
      .LoadPC    (LoadPC),
      .LoadReg   (LoadReg),
      .LoadAcc   (LoadAcc),
      .SelAcc    (SelAcc),
      .SelALU    (SelALU),
      .Halted    (Halted),
      .Fault     (Fault),
      .IllegalOp (IllegalOp)
`ifdef CTRL_PERF_CNT_EN
      ,
      .RetiredCnt(RetiredCnt),
      .StallCnt  (StallCnt)
`endif
   );

   // Free-running clock, 10 time units per cycle.
   always #5 Clk = ~Clk;

   // Hard stop in case a scenario loses its way.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic outVec_t sampleDut();
      outVec_t v;
      v.memReq  = busIf.MemReq;
      v.loadIR  = busIf.LoadIR;
      v.incPC   = IncPC;
      v.selPC   = SelPC;
      v.loadPC  = LoadPC;
      v.loadReg = LoadReg;
      v.loadAcc = LoadAcc;
      v.selAcc  = SelAcc;
      v.selALU  = SelALU;
      v.halted  = Halted;
      v.fault   = Fault;
      return v;
   endfunction

   function automatic logic isIllegal(input logic [7:0] op);
      return (op > 8'd15) || (op == 8'd9);
   endfunction

   // Instruction table: what each opcode does in its EXEC cycle.
   function automatic outVec_t execModel(input logic [7:0] op, input logic z, input logic c);
      outVec_t e;
      int      eff;
      e   = '0;
      eff = isIllegal(op) ? 0 : int'(op);
      case (eff)
         1, 2, 3, 11, 12: begin
            e.selALU  = 6'(eff);
            e.loadAcc = 1'b1;
         end
         4:  begin e.selAcc = 2'd1; e.loadAcc = 1'b1; end
         5:  e.loadReg = 1'b1;
         13: begin e.selAcc = 2'd2; e.loadAcc = 1'b1; end
         6:  e.loadPC = z;
         7:  begin e.loadPC = z; e.selPC = 1'b1; end
         8:  e.loadPC = c;
         10: begin e.loadPC = c; e.selPC = 1'b1; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic nextCycle();
      @(posedge Clk);
      #1;
   endtask

   // Drive the inputs for the current cycle and let the outputs settle.
   task automatic applyStimulus(input logic ack, input logic [7:0] op,
                                input logic z, input logic c, input logic res);
      busIf.MemAck = ack;
      busIf.Opcode = op;
      Z            = z;
      C            = c;
      Resume       = res;
      #2;
   endtask

   // Starts in a FETCH cycle and walks one instruction through FETCH (with
   // ackDelay wait cycles), DECODE and EXEC. Resume is randomised outside
   // HALT/FAULT since it must be ignored there.
   task automatic runInstruction(input logic [7:0] op, input int ackDelay,
                                 input logic z, input logic c, input logic resetInExec);
      outVec_t exp;
      outVec_t obs;
      for (int i = 0; i < ackDelay; i++) begin
         applyStimulus(1'b0, 8'($urandom), rbit(), rbit(), rbit());
         exp = '0;
         exp.memReq = 1'b1;
         obs = sampleDut();
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL fetch_wait op=%h wait=%0d: got %h expected %h", op, i, obs, exp);
         end
         modelStall++;
         nextCycle();
      end

      applyStimulus(1'b1, 8'($urandom), rbit(), rbit(), rbit());
      exp = '0;
      exp.memReq = 1'b1;
      exp.loadIR = 1'b1;
      exp.incPC  = 1'b1;
      obs = sampleDut();
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL fetch_ack op=%h: got %h expected %h", op, obs, exp);
      end
      nextCycle();

      applyStimulus(rbit(), op, rbit(), rbit(), rbit());
      exp = '0;
      obs = sampleDut();
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL decode op=%h: got %h expected %h", op, obs, exp);
      end
      if (isIllegal(op)) modelIllegal = 1'b1;
      nextCycle();

      // Opcode is scrambled here: EXEC must act on the latched opcode.
      applyStimulus(rbit(), 8'($urandom), z, c, rbit());
      if (resetInExec) CLB = 1'b0;
      exp = execModel(op, z, c);
      obs = sampleDut();
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL exec op=%h z=%b c=%b: got %h expected %h", op, z, c, obs, exp);
      end
      compared++;
      if (IllegalOp !== modelIllegal) begin
         mismatched++;
         $display("[TB] FAIL illegal_flag op=%h: got %b expected %b", op, IllegalOp, modelIllegal);
      end
      modelRetired++;
      nextCycle();
   endtask

   task automatic test_reset();
      outVec_t obs;
      CLB = 1'b0;
      applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      nextCycle();
      nextCycle();
      CLB = 1'b1;
      modelIllegal = 1'b0;
      modelRetired = 0;
      modelStall   = 0;
      applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      obs = sampleDut();
      compared++;
      if (obs !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_idle_outputs: got %h expected %h", obs, outVec_t'('0));
      end
      compared++;
      if (IllegalOp !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_illegal: got %b expected 0", IllegalOp);
      end
      nextCycle();
   endtask

   task automatic test_alu_ops();
      logic [7:0] ops [5];
      ops = '{8'h01, 8'h02, 8'h03, 8'h0B, 8'h0C};
      runInstruction(8'h01, 0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         runInstruction(ops[i], $urandom_range(0, 3), rbit(), rbit(), 1'b0);
      end
      runInstruction(8'h04, 1, rbit(), rbit(), 1'b0);
      runInstruction(8'h05, 2, rbit(), rbit(), 1'b0);
      runInstruction(8'h0D, 0, rbit(), rbit(), 1'b0);
      runInstruction(8'h00, 0, rbit(), rbit(), 1'b0);
   endtask

   task automatic test_jumps();
      runInstruction(8'h06, 0, 1'b1, 1'b0, 1'b0);
      runInstruction(8'h06, 0, 1'b0, 1'b1, 1'b0);
      runInstruction(8'h07, 1, 1'b1, 1'b0, 1'b0);
      runInstruction(8'h07, 0, 1'b0, 1'b1, 1'b0);
      runInstruction(8'h08, 0, 1'b0, 1'b1, 1'b0);
      runInstruction(8'h08, 2, 1'b1, 1'b0, 1'b0);
      runInstruction(8'h0A, 0, 1'b0, 1'b1, 1'b0);
      runInstruction(8'h0A, 0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      outVec_t exp;
      outVec_t obs;
      for (int i = 0; i < FETCH_TIMEOUT; i++) begin
         applyStimulus(1'b0, 8'($urandom), rbit(), rbit(), rbit());
         exp = '0;
         exp.memReq = 1'b1;
         obs = sampleDut();
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL timeout_wait cycle=%0d: got %h expected %h", i, obs, exp);
         end
         modelStall++;
         nextCycle();
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(rbit(), 8'($urandom), rbit(), rbit(), (i == 3) ? 1'b1 : 1'b0);
         exp = '0;
         exp.fault = 1'b1;
         obs = sampleDut();
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL fault_hold cycle=%0d: got %h expected %h", i, obs, exp);
         end
         nextCycle();
      end
      // Back in FETCH with a cleared counter: an ack on the limit cycle wins.
      runInstruction(8'h02, FETCH_TIMEOUT - 1, rbit(), rbit(), 1'b0);
   endtask

   task automatic test_halt();
      outVec_t exp;
      outVec_t obs;
      runInstruction(8'h0F, $urandom_range(0, 2), rbit(), rbit(), 1'b0);
      for (int i = 0; i < 21; i++) begin
         applyStimulus(rbit(), 8'($urandom), rbit(), rbit(), (i == 20) ? 1'b1 : 1'b0);
         exp = '0;
         exp.halted = 1'b1;
         obs = sampleDut();
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL halt_hold cycle=%0d: got %h expected %h", i, obs, exp);
         end
         nextCycle();
      end
      applyStimulus(1'b0, 8'($urandom), rbit(), rbit(), rbit());
      exp = '0;
      exp.memReq = 1'b1;
      obs = sampleDut();
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL halt_resume_fetch: got %h expected %h", obs, exp);
      end
      modelStall++;
      nextCycle();
      runInstruction(8'h03, $urandom_range(0, 3), rbit(), rbit(), 1'b0);
   endtask

   task automatic test_illegal();
      runInstruction(8'h09, 0, rbit(), rbit(), 1'b0);
      runInstruction(8'h11, 1, rbit(), rbit(), 1'b0);
      runInstruction(8'h1F, 0, rbit(), rbit(), 1'b0);
      runInstruction(8'h01, 0, rbit(), rbit(), 1'b0);
      runInstruction(8'h06, 0, 1'b1, rbit(), 1'b0);
   endtask

   task automatic test_reset_mid_exec();
      outVec_t obs;
      runInstruction(8'h04, 0, rbit(), rbit(), 1'b1);
      modelIllegal = 1'b0;
      modelRetired = 0;
      modelStall   = 0;
      applyStimulus(1'b1, 8'($urandom), rbit(), rbit(), rbit());
      obs = sampleDut();
      compared++;
      if (obs !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_mid_exec_outputs: got %h expected %h", obs, outVec_t'('0));
      end
      compared++;
      if (IllegalOp !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_mid_exec_illegal: got %b expected 0", IllegalOp);
      end
      CLB = 1'b1;
      applyStimulus(1'b1, 8'($urandom), rbit(), rbit(), rbit());
      obs = sampleDut();
      compared++;
      if (obs !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_release_idle: got %h expected %h", obs, outVec_t'('0));
      end
      nextCycle();
   endtask

   task automatic test_back_to_back();
      outVec_t    exp;
      outVec_t    obs;
      logic [7:0] op;
      for (int n = 0; n < 40; n++) begin
         op = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
         runInstruction(op, $urandom_range(0, 3), rbit(), rbit(), 1'b0);
         if (op == 8'h0F) begin
            applyStimulus(rbit(), 8'($urandom), rbit(), rbit(), 1'b1);
            exp = '0;
            exp.halted = 1'b1;
            obs = sampleDut();
            compared++;
            if (obs !== exp) begin
               mismatched++;
               $display("[TB] FAIL b2b_halt n=%0d: got %h expected %h", n, obs, exp);
            end
            nextCycle();
         end
      end
   endtask

   task automatic test_perf_counters();
`ifdef CTRL_PERF_CNT_EN
      compared++;
      if (RetiredCnt !== 16'(modelRetired)) begin
         mismatched++;
         $display("[TB] FAIL retired_cnt: got %0d expected %0d", RetiredCnt, modelRetired);
      end
      compared++;
      if (StallCnt !== 16'(modelStall)) begin
         mismatched++;
         $display("[TB] FAIL stall_cnt: got %0d expected %0d", StallCnt, modelStall);
      end
`endif
   endtask

   // Scenario sequence; each scenario leaves the controller in FETCH.
   initial begin
      CLB          = 1'b0;
      busIf.MemAck = 1'b0;
      busIf.Opcode = '0;
      Z            = 1'b0;
      C            = 1'b0;
      Resume       = 1'b0;
      $display("[TB] starting param_controller_fsm bench");
      test_reset();
      test_alu_ops();
      test_jumps();
      test_perf_counters();
      test_timeout();
      test_halt();
      test_illegal();
      test_perf_counters();
      test_reset_mid_exec();
      test_perf_counters();
      test_back_to_back();
      test_perf_counters();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
